// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit with its own sequencing FSM.
// Sits beside the execute-stage ALU. It takes one M-extension op at a time,
// stalls the pipeline while it iterates (one bit per cycle), and then presents
// a one-cycle result that the execute stage registers in place of the ALU result.
//
// Ports:
//   clk_i     - clock, rising edge
//   rstn_i    - asynchronous active-low reset
//   start_i   - valid M-op present on op_i/op1_i/op2_i
//   op_i      - funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   op1_i     - rs1 value
//   op2_i     - rs2 value
//   flush_i   - kill any in-flight op (branch/exception)
//   stall_o   - hold upstream pipeline registers
//   busy_o    - FSM not in IDLE
//   valid_o   - result_o valid this cycle
//   result_o  - result, held until the next op loads it
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                valid_q, valid_d;

    logic                signed1, signed2, neg1, neg2;
    logic [XLEN-1:0]     mag1, mag2;
    logic                div_by_zero, div_ovf;
    logic [XLEN-1:0]     mul_addend;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_shift;
    logic [XLEN+1:0]     div_diff;
    logic                div_ge;
    logic [2*XLEN-1:0]   iter_next;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot_fix, rem_fix, final_res;

    // Operand decode for a new op: which operands are signed, their magnitudes,
    // and the divide corner cases that bypass the iteration entirely.
    always_comb begin
        signed1     = !(op_i == 3'd3 || op_i == 3'd5 || op_i == 3'd7);
        signed2     = signed1 && (op_i != 3'd2);
        neg1        = signed1 && op1_i[XLEN-1];
        neg2        = signed2 && op2_i[XLEN-1];
        mag1        = neg1 ? -op1_i : op1_i;
        mag2        = neg2 ? -op2_i : op2_i;
        div_by_zero = op_i[2] && (op2_i == '0);
        div_ovf     = (op_i == 3'd4 || op_i == 3'd6) &&
                      (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
    end

    // One iteration of either engine. Multiply: right-shifting shift-add, the
    // high half accumulates while finished product bits shift into the low half.
    // Divide: restoring; the low half starts as the dividend and fills with
    // quotient bits, the high half holds the partial remainder.
    always_comb begin
        mul_addend = b_q[0] ? a_q : '0;
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
        div_shift  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff   = {1'b0, div_shift} - {2'b00, b_q};
        div_ge     = !div_diff[XLEN+1];
        if (op_q[2]) begin
            iter_next = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                         acc_q[XLEN-2:0], div_ge};
        end else begin
            iter_next = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign correction applied to the value produced by the final iteration.
    always_comb begin
        prod_fix = neg_res_q ? -iter_next : iter_next;
        quot_fix = neg_res_q ? -iter_next[XLEN-1:0] : iter_next[XLEN-1:0];
        rem_fix  = neg_rem_q ? -iter_next[2*XLEN-1:XLEN] : iter_next[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:               final_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:   final_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:         final_res = quot_fix;
            default:            final_res = rem_fix;
        endcase
    end

    // Next-state logic. flush_i overrides everything and leaves result_o alone;
    // valid_d simply marks entry into DONE so valid_o is a clean register.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d      = op_i;
                    neg_res_d = neg1 ^ neg2;
                    neg_rem_d = neg1;
                    a_d       = mag1;
                    b_d       = mag2;
                    cnt_d     = '0;
                    acc_d     = op_i[2] ? {{XLEN{1'b0}}, mag1} : '0;
                    if (div_by_zero) begin
                        result_d = op_i[1] ? op1_i : '1;
                        state_d  = DONE;
                    end else if (div_ovf) begin
                        result_d = op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        state_d  = DONE;
                    end else begin
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                acc_d = iter_next;
                b_d   = op_q[2] ? b_q : (b_q >> 1);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d = final_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush_i) begin
            state_d  = IDLE;
            result_d = result_q;
        end
        valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

    assign stall_o  = ((state_q == IDLE) && start_i && !flush_i) || (state_q == BUSY);
    assign busy_o   = (state_q != IDLE);
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq. Stimulus pushes the
// hand-computed result into a scoreboard queue; a monitor pops and compares it
// whenever valid_o is seen. Latency, stall/busy behaviour, flush and
// asynchronous reset are checked from the stimulus process.
module tb_muldiv_seq;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int          compared;
    int          mismatched;
    logic [31:0] expQ[$];
    logic [31:0] lastExp;

    muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .start_i  (start),
        .op_i     (op),
        .op1_i    (op1),
        .op2_i    (op2),
        .flush_i  (flush),
        .stall_o  (stall),
        .busy_o   (busy),
        .valid_o  (valid),
        .result_o (result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every valid_o pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (rstn && valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedValid", 32'd1, 32'd0);
            end else begin
                checkOutput("result", result, expQ.pop_front());
            end
        end
    end

    // Issue one op, then follow it to its valid cycle checking latency and
    // stall/busy on every cycle. Operands are scrambled once the op is accepted.
    task automatic applyStimulus(input logic [2:0] opc, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp,
                                 input int expLat);
        int lat;
        int err;
        @(negedge clk);
        start = 1'b1;
        op    = opc;
        op1   = a;
        op2   = b;
        #1;
        checkOutput("stallAtAccept", {31'd0, stall}, 32'd1);
        expQ.push_back(exp);
        lastExp = exp;
        lat = -1;
        err = 0;
        @(posedge clk);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (valid) begin
                lat = k;
                if (stall !== 1'b0 || busy !== 1'b1) err++;
                break;
            end
            if (stall !== 1'b1 || busy !== 1'b1) err++;
            if (k == 1) begin
                start = 1'b0;
                op1   = $urandom;
                op2   = $urandom;
            end
        end
        start = 1'b0;
        checkOutput("latency", lat, expLat);
        checkOutput("stallBusyTrace", err, 32'd0);
    endtask

    initial begin
        int v;
        compared   = 0;
        mismatched = 0;
        lastExp    = '0;
        clk   = 1'b0;
        rstn  = 1'b1;
        start = 1'b0;
        op    = '0;
        op1   = '0;
        op2   = '0;
        flush = 1'b0;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetBusy",   {31'd0, busy},  32'd0);
        checkOutput("resetValid",  {31'd0, valid}, 32'd0);
        checkOutput("resetResult", result,         32'd0);
        checkOutput("resetStall",  {31'd0, stall}, 32'd0);
        rstn = 1'b1;

        // Multiplies
        applyStimulus(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        applyStimulus(3'd0, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0000001E, 33);
        applyStimulus(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        applyStimulus(3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        applyStimulus(3'd2, 32'h80000000, 32'h80000000, 32'hC0000000, 33);
        applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        applyStimulus(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        // Divides
        applyStimulus(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        applyStimulus(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        applyStimulus(3'd5, 32'd100,      32'd7,        32'd14,       33);
        applyStimulus(3'd7, 32'd100,      32'd7,        32'd2,        33);
        applyStimulus(3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        applyStimulus(3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33);
        applyStimulus(3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33);
        applyStimulus(3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
        // Fast paths
        applyStimulus(3'd6, 32'd5,        32'd0,        32'd5,        1);
        applyStimulus(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        applyStimulus(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
        applyStimulus(3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        applyStimulus(3'd7, 32'd9,        32'd0,        32'd9,        1);
        applyStimulus(3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);

        // Flush at BUSY cycle 10: no result, no valid, back to IDLE
        @(negedge clk);
        start = 1'b1;
        op    = 3'd0;
        op1   = 32'h12345678;
        op2   = 32'd9;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flushBusy",  {31'd0, busy},  32'd0);
        checkOutput("flushStall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        v = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid) v++;
        end
        checkOutput("flushNoValid", v, 32'd0);
        checkOutput("flushKeepsResult", result, lastExp);
        applyStimulus(3'd0, 32'd3, 32'd4, 32'd12, 33);

        // Asynchronous reset mid-BUSY
        @(negedge clk);
        start = 1'b1;
        op    = 3'd0;
        op1   = 32'd7;
        op2   = 32'd7;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3;
        rstn  = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("asyncResetBusy",   {31'd0, busy},  32'd0);
        checkOutput("asyncResetValid",  {31'd0, valid}, 32'd0);
        checkOutput("asyncResetResult", result,         32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // start_i held high through DONE yields exactly one valid pulse
        @(negedge clk);
        start = 1'b1;
        op    = 3'd5;
        op1   = 32'd100;
        op2   = 32'd7;
        expQ.push_back(32'd14);
        v = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (valid) begin
                v++;
                start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput("heldStartPulses", v, 32'd1);

        repeat (2) @(negedge clk);
        checkOutput("scoreboardDrained", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide unit with its own sequencing FSM, placed beside the execute-stage ALU.
- Accepts one M-extension op at a time from the decode/execute boundary.
- Stalls the pipeline while it iterates, then presents a one-cycle result for the execute stage to register in place of the ALU result.

Parameters:
- XLEN, 32, operand/result width; the only supported value is 32.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == XLEN.

Ports:
- clk_i  input  1  clock, rising edge.
- rstn_i  input  1  asynchronous active-low reset.
- start_i  input  1  valid M-op present on op_i/op1_i/op2_i.
- op_i  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op1_i  input  XLEN  rs1 value.
- op2_i  input  XLEN  rs2 value.
- flush_i  input  1  kill any in-flight op (branch/exception).
- stall_o  output  1  hold upstream pipeline registers.
- busy_o  output  1  FSM not in IDLE.
- valid_o  output  1  result_o valid this cycle.
- result_o  output  XLEN  result.

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset (asynchronous, rstn_i low) sets state=IDLE, counter=0, and every internal register, result_o and valid_o to 0.
- IDLE, start_i=1, flush_i=0:
  - Latch op_i.
  - Latch operand magnitudes and result sign.
    - Signed operand: MUL/MULH/DIV/REM both operands; MULHSU op1 only.
  - Clear the accumulator, counter=0.
  - Next state BUSY, except the fast paths below.
- Fast paths from IDLE go straight to DONE with the result loaded:
  - DIV/DIVU with op2=0: quotient 0xFFFFFFFF.
  - REM/REMU with op2=0: result = op1.
  - DIV with op1=0x80000000 and op2=0xFFFFFFFF: result 0x80000000; REM in the same case: result 0.
- BUSY, one iteration per cycle, counter increments by 1:
  - Multiply: unsigned shift-add on magnitudes into a 2*XLEN accumulator.
  - Divide: restoring, unsigned on magnitudes.
  - When counter==XLEN-1, apply sign correction and load result_o, then go to DONE.
  - Multiply sign correction: two's-complement negate the 64-bit product if the signs differ.
  - Divide sign correction: quotient sign = sign1 XOR sign2; remainder sign = sign of op1.
- Result selection:
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: valid_o=1 for exactly this cycle; next state IDLE unconditionally. start_i is ignored here because it is still the same instruction.
- Latency:
  - Normal op: accept edge, then 32 BUSY cycles; valid_o high on the 33rd cycle after the accept edge.
  - Fast path: valid_o high 1 cycle after the accept edge.
- stall_o is combinational: stall_o = (IDLE & start_i & ~flush_i) | BUSY. It is 0 in DONE so the pipeline advances while valid_o=1.
- busy_o = (state != IDLE).
- result_o holds its value after DONE until the next op loads it. valid_o is registered.
- flush_i in any state: next state IDLE, valid_o=0 next cycle, no result written. flush_i has priority over start_i and over the DONE transition.
- A new op is accepted at the earliest in the cycle after DONE, i.e. back-to-back ops are separated by one IDLE cycle.
- Reset asserted mid-operation: immediate IDLE; the partial op is discarded.
- Operands are sampled only at the accept edge; op1_i/op2_i changes during BUSY have no effect.

Test Plan:
- MUL 7 x -3 (op1=7, op2=0xFFFFFFFD) -> valid_o on cycle 33, result 0xFFFFFFEB; stall_o high cycles 0..32, low on the valid cycle.
- MULH/MULHU/MULHSU with op1=op2=0x80000000:
  - MULH -> 0x40000000.
  - MULHU -> 0x40000000.
  - MULHSU -> 0xC0000000.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Fast paths, each with valid_o 1 cycle after accept and no BUSY cycles:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- flush_i pulsed at BUSY cycle 10 -> IDLE next cycle, valid_o never asserted, stall_o drops. A following MUL 3x4 returns 12.
- rstn_i pulled low asynchronously mid-BUSY (between clock edges) -> busy_o, valid_o and result_o go 0 immediately. After release, start_i held high through DONE produces exactly one valid_o pulse.
